// File: rtl/snes_pad_pkg.sv
// snes_pad_pkg: shared definitions for the SNES/NES pad responder.
// Holds the FSM encoding, the legal frame lengths and the button bit positions
// for both pad types. Optional turbo logic lives behind SNES_PAD_RESPONDER_TURBO_EN.
package snes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

    localparam int SNES_BITS    = 16;
    localparam int NES_BITS     = 8;
    localparam int BUTTON_WIDTH = 12;

    // SNES serial order, bit i goes out as serial bit i
    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    // NES serial order, uses the low byte only
    localparam int NES_A     = 0;
    localparam int NES_B     = 1;
    localparam int NES_SEL   = 2;
    localparam int NES_START = 3;
    localparam int NES_UP    = 4;
    localparam int NES_DOWN  = 5;
    localparam int NES_LEFT  = 6;
    localparam int NES_RIGHT = 7;

endpackage

// File: rtl/tts_sync_edge.sv
// tts_sync_edge: multi-flop synchroniser for one asynchronous level, plus a
// history flop so single-cycle rise/fall pulses can be derived in the clk domain.
// RESET_VAL lets an idle-high line (the pad clock) come out of reset without
// producing a spurious edge.
module tts_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Move the raw level through the synchroniser chain and keep one flop of history behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~hist_q;
    assign fall     = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device side of the NES/SNES pad serial protocol.
// Latch high reloads the button word, latch fall starts a frame, each pad-clock
// rise shifts the next bit onto the active-low data line.
// Optional turbo on buttons[1:0] is enabled with `define SNES_PAD_RESPONDER_TURBO_EN.
module snes_pad_responder #(
    parameter int NUM_BITS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        latch_in,
    input  logic        pclk_in,
    input  logic [11:0] buttons,
`ifdef SNES_PAD_RESPONDER_TURBO_EN
    input  logic [1:0]  turbo_mask,
`endif
    output logic        data_out,
    output logic        busy,
    output logic        poll_strobe,
    output logic [4:0]  bit_idx
);

    import snes_pad_pkg::*;

    localparam logic [4:0] LAST_IDX    = 5'(NUM_BITS);
    localparam bit         NUM_BITS_OK = (NUM_BITS == SNES_BITS) || (NUM_BITS == NES_BITS);

    logic latch_sync, latch_rise, latch_fall;
    logic pclk_sync, pclk_rise, pclk_fall;

    tts_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (latch_in),
        .sync_out (latch_sync),
        .rise     (latch_rise),
        .fall     (latch_fall)
    );

    tts_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_pclk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (pclk_in),
        .sync_out (pclk_sync),
        .rise     (pclk_rise),
        .fall     (pclk_fall)
    );

    logic [11:0] gated;

`ifdef SNES_PAD_RESPONDER_TURBO_EN
    localparam int TW = (TURBO_DIV < 2) ? 1 : $clog2(TURBO_DIV + 1);

    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    // Count completed polls; every TURBO_DIV polls flip the phase so turbo buttons alternate in blocks
    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (poll_strobe) begin
            if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
                turbo_cnt   <= '0;
                turbo_phase <= ~turbo_phase;
            end else begin
                turbo_cnt <= turbo_cnt + 1'b1;
            end
        end
    end

    // Phase clear after reset is the "pressed" window, so a held turbo button reads pressed first
    always_comb begin
        gated        = buttons;
        gated[BTN_B] = buttons[BTN_B] & ~(turbo_mask[0] & turbo_phase);
        gated[BTN_Y] = buttons[BTN_Y] & ~(turbo_mask[1] & turbo_phase);
    end
`else
    localparam int TURBO_DIV_UNUSED = TURBO_DIV;
    assign gated = buttons;
`endif

    logic [15:0]         padded;
    logic [NUM_BITS-1:0] load;

    assign padded = {4'b0000, gated};
    assign load   = padded[NUM_BITS-1:0];

    logic unused_sigs;
    assign unused_sigs = ^{latch_rise, pclk_sync, pclk_fall, NUM_BITS_OK, padded};

    pad_state_t          state, state_n;
    logic [NUM_BITS-1:0] shreg, shreg_n;
    logic [4:0]          bit_idx_n;
    logic                data_out_n, busy_n, poll_strobe_n;

    // State and all outputs are registered so data_out never glitches toward the console
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            data_out    <= 1'b1;
            busy        <= 1'b0;
            poll_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_idx     <= bit_idx_n;
            data_out    <= data_out_n;
            busy        <= busy_n;
            poll_strobe <= poll_strobe_n;
        end
    end

    // Latch high from any other state wins over a same-cycle pad clock and aborts/reloads the frame
    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        bit_idx_n     = bit_idx;
        data_out_n    = data_out;
        busy_n        = busy;
        poll_strobe_n = 1'b0;

        if (state != LATCH && latch_sync) begin
            state_n    = LATCH;
            shreg_n    = load;
            bit_idx_n  = '0;
            data_out_n = ~load[0];
            busy_n     = 1'b0;
        end else begin
            unique case (state)
                LATCH: begin
                    if (latch_fall) begin
                        state_n       = SHIFT;
                        poll_strobe_n = 1'b1;
                        busy_n        = 1'b1;
                    end else begin
                        shreg_n    = load;
                        bit_idx_n  = '0;
                        data_out_n = ~load[0];
                    end
                end
                SHIFT: begin
                    if (pclk_rise) begin
                        shreg_n   = {1'b0, shreg[NUM_BITS-1:1]};
                        bit_idx_n = bit_idx + 5'd1;
                        if (bit_idx_n == LAST_IDX) begin
                            state_n    = DONE;
                            data_out_n = 1'b1;
                            busy_n     = 1'b0;
                        end else begin
                            data_out_n = ~shreg_n[0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
